uart_tx_stream: RTL and testbench
=================================

# uart_tx_stream

Testbench-side UART transmitter that buffers bytes from a stimulus source in a small FIFO and serialises them as 8N1 (or 8N2) frames on a single TXD line. It sits directly upstream of the serial capture device: TXD connects to that device's RXD, with both blocks on the same bit clock. Stimulus code writes characters through a valid/ready port, and the block emits them back-to-back with no idle gap between frames.

## Interface
- FIFO_DEPTH, 16: byte FIFO entries; power of two, >= 2.
- BAUD_DIV, 1: CLK cycles per serial bit; >= 1. Use 1 when CLK is the bit clock.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- CLK  input  1  clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- WR_VALID  input  1  stimulus presents a byte.
- WR_DATA  input  8  byte to transmit.
- WR_READY  output  1  FIFO can accept a byte.
- TXD  output  1  serial line; idle high.
- BUSY  output  1  frame in progress or FIFO non-empty.
- FIFO_COUNT  output  $clog2(FIFO_DEPTH)+1  bytes held in the FIFO, excluding the byte being shifted.
- TX_DONE  output  1  one-cycle pulse at the end of each frame's last stop bit.

## Operation
- Reset values: TXD=1, WR_READY=0 while RESET is high, BUSY=0, FIFO_COUNT=0, TX_DONE=0, FSM=IDLE, FIFO flushed.
- Write: a byte is accepted on a rising edge when WR_VALID and WR_READY are both high.
  - WR_READY = (FIFO_COUNT < FIFO_DEPTH) and not RESET. It depends only on registered state.
  - When the FIFO is full, WR_READY is 0 even if a pop occurs in the same cycle. The freed slot is visible the next cycle.
- FIFO: circular buffer with read and write pointers that wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave FIFO_COUNT unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1. If FIFO_COUNT != 0, pop into the shift register and go to START.
  - START: TXD=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: TXD = shift[0], LSB first, each bit held for BAUD_DIV cycles. After bit 7, go to STOP.
  - STOP: TXD=1 for STOP_BITS*BAUD_DIV cycles. On the final cycle, pulse TX_DONE. Then:
    - if FIFO non-empty, pop and go directly to START (no idle cycle);
    - otherwise go to IDLE.
- Baud counter: loads BAUD_DIV-1 on entry to each bit and decrements to 0; the bit ends at 0. Its width is $clog2(BAUD_DIV)+1 so BAUD_DIV=1 is legal.
- BUSY = (state != IDLE) or (FIFO_COUNT != 0).
- Reset mid-frame: TXD returns to 1 immediately (asynchronous) and all FIFO contents are discarded. The downstream device may see a truncated frame; benches must not reset mid-frame unless that is the scenario under test.
- Writing while a frame is in progress is always legal.

## Timing
- Byte accepted at edge N into an empty FIFO with FSM in IDLE:
  - pop and IDLE->START happen at edge N+1;
  - the start bit is on TXD from edge N+1 to edge N+1+BAUD_DIV.
- Frame length: (9+STOP_BITS)*BAUD_DIV cycles.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit cycle.
- TX_DONE is high during the last stop-bit cycle only.
- FIFO_COUNT updates on the edge of the push or pop.
- With BAUD_DIV=1, STOP_BITS=1, each byte occupies exactly 10 CLK cycles, matching one 10-cycle frame of the downstream capture device's shift register.

## Test plan
- Reset: hold RESET for 3 cycles with WR_VALID=1 -> TXD=1, WR_READY=0, FIFO_COUNT=0, no byte accepted; WR_READY=1 on the first cycle after release.
- Single byte, BAUD_DIV=1: write 0xA5 at edge N -> from edge N+1 TXD = 0,1,0,1,0,0,1,0,1,1 (one value per cycle), TX_DONE pulses on the 10th cycle, BUSY falls after it.
- Burst with TXD looped to the capture device: write "Hi", 0x0A, 0x04 -> frames back-to-back with no idle cycles; the downstream device prints "Hi" on one line and ends the simulation.
- Full FIFO, FIFO_DEPTH=4, WR_VALID held high with 8 bytes:
  - 5 bytes are accepted (1 popped into the shift register at once, 4 queued);
  - WR_READY then stays 0 until the first TX_DONE;
  - all 8 bytes are transmitted in order.
- BAUD_DIV=3, STOP_BITS=2: write 0x00 -> TXD low for 27 cycles, then high for 6 cycles; frame length is 33 cycles.
- Reset mid-frame: assert RESET during DATA bit 4 with 3 bytes queued -> TXD=1 at once, FIFO_COUNT=0; after release no further frames are sent without new writes.

Source files
------------

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: byte FIFO feeding an 8N1/8N2 serial transmitter.
// Stimulus pushes bytes over a valid/ready port; frames leave back-to-back on txd_o
// with no idle gap while the FIFO has data.
//
// Ports:
//   clk_i          bit/system clock, all state on rising edge
//   rst_i          asynchronous active-high reset
//   wr_valid_i     stimulus presents a byte
//   wr_data_i      byte to transmit
//   wr_ready_o     FIFO can accept a byte (low during reset)
//   txd_o          serial line, idle high
//   busy_o         frame in progress or FIFO non-empty
//   fifo_count_o   bytes queued, excluding the one being shifted
//   tx_done_o      one-cycle pulse during the last stop-bit cycle
module uart_tx_stream #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_DIV   = 1,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          wr_valid_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ready_o,
  output logic                          txd_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          tx_done_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV) + 1;

  localparam logic [CntW-1:0]  DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
  // The stop phase is timed as one long bit; 2*BAUD_DIV-1 still fits in BaudW bits.
  localparam logic [BaudW-1:0] StopLast = BaudW'(STOP_BITS * BAUD_DIV - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  state_e           state_q;
  logic [7:0]       shift_q;
  logic [2:0]       bit_idx_q;
  logic [BaudW-1:0] baud_q;
  logic             txd_q;
  logic             tx_done_q;

  logic push, pop;

  // Ready looks only at registered occupancy, so a pop in a full cycle does not open it.
  assign wr_ready_o = (count_q < DepthCnt) && !rst_i;
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = (count_q != '0) &&
                      ((state_q == StIdle) || ((state_q == StStop) && (baud_q == '0)));

  assign txd_o        = txd_q;
  assign tx_done_o    = tx_done_q;
  assign fifo_count_o = count_q;
  assign busy_o       = (state_q != StIdle) || (count_q != '0);

  // Storage is not reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      txd_q     <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          txd_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= StStart;
            txd_q   <= 1'b0;
            baud_q  <= BaudLast;
          end
        end
        StStart: begin
          if (baud_q == '0) begin
            state_q   <= StData;
            txd_q     <= shift_q[0];
            bit_idx_q <= '0;
            baud_q    <= BaudLast;
          end else begin
            baud_q <= baud_q - BaudW'(1);
          end
        end
        StData: begin
          if (baud_q == '0) begin
            if (bit_idx_q == 3'd7) begin
              state_q   <= StStop;
              txd_q     <= 1'b1;
              baud_q    <= StopLast;
              // Single-cycle stop phase: entry cycle is already the last one.
              tx_done_q <= (StopLast == '0);
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
              baud_q    <= BaudLast;
            end
          end else begin
            baud_q <= baud_q - BaudW'(1);
          end
        end
        StStop: begin
          if (baud_q == '0) begin
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= StStart;
              txd_q   <= 1'b0;
              baud_q  <= BaudLast;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q    <= baud_q - BaudW'(1);
            tx_done_q <= (baud_q == BaudW'(1));
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
module tb_uart_tx_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: FIFO_DEPTH=4, BAUD_DIV=1, STOP_BITS=1
  logic       a_rst, a_valid, a_ready, a_txd, a_busy, a_done;
  logic [7:0] a_data;
  logic [2:0] a_count;

  // Instance B: FIFO_DEPTH=4, BAUD_DIV=3, STOP_BITS=2
  logic       b_rst, b_valid, b_ready, b_txd, b_busy, b_done;
  logic [7:0] b_data;
  logic [2:0] b_count;

  uart_tx_stream #(.FIFO_DEPTH(4), .BAUD_DIV(1), .STOP_BITS(1)) u_a (
    .clk_i(clk), .rst_i(a_rst), .wr_valid_i(a_valid), .wr_data_i(a_data),
    .wr_ready_o(a_ready), .txd_o(a_txd), .busy_o(a_busy), .fifo_count_o(a_count),
    .tx_done_o(a_done)
  );

  uart_tx_stream #(.FIFO_DEPTH(4), .BAUD_DIV(3), .STOP_BITS(2)) u_b (
    .clk_i(clk), .rst_i(b_rst), .wr_valid_i(b_valid), .wr_data_i(b_data),
    .wr_ready_o(b_ready), .txd_o(b_txd), .busy_o(b_busy), .fifo_count_o(b_count),
    .tx_done_o(b_done)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {stop, data LSB..MSB, start}: bit 0 is the first value on the line.
  function automatic logic [9:0] frame10(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  logic [7:0]  burst  [4];
  logic [7:0]  fbytes [9];
  logic [7:0]  mbytes [4];
  logic [99:0] bits;
  logic [39:0] rx, rx_done, exp_done;
  logic [39:0] bvec, bdone, bexp;
  int          idx, first_done, rdy_early, n_done, bad, not_ready;
  logic        rdy_prev;

  initial begin
    burst  = '{8'h48, 8'h69, 8'h0A, 8'h04};
    fbytes = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h00};
    mbytes = '{8'h2C, 8'h11, 8'h22, 8'h33};

    // Reset held 3 cycles with valid asserted
    a_rst = 1'b1; a_valid = 1'b1; a_data = 8'h55;
    b_rst = 1'b1; b_valid = 1'b0; b_data = 8'h00;
    repeat (3) begin
      @(negedge clk);
      check("rst_txd",   64'(a_txd),   64'(1));
      check("rst_ready", 64'(a_ready), 64'(0));
      check("rst_count", 64'(a_count), 64'(0));
    end
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    a_rst = 1'b0; b_rst = 1'b0; a_valid = 1'b0;
    @(negedge clk);
    check("rel_ready", 64'(a_ready), 64'(1));
    check("rel_count", 64'(a_count), 64'(0));
    check("rel_txd",   64'(a_txd),   64'(1));

    // Single byte 0xA5
    a_valid = 1'b1; a_data = 8'hA5;
    @(negedge clk);
    a_valid = 1'b0;
    check("one_count", 64'(a_count), 64'(1));
    check("one_busy",  64'(a_busy),  64'(1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("one_txd",  64'(a_txd),  64'(frame10(8'hA5) >> i) & 64'(1));
      check("one_done", 64'(a_done), 64'(i == 9));
    end
    @(negedge clk);
    check("one_busy_end", 64'(a_busy), 64'(0));
    check("one_done_end", 64'(a_done), 64'(0));

    // Burst "Hi\n\x04": four frames with no idle cycles between them
    rx = '0; rx_done = '0; exp_done = '0; not_ready = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 41) begin
        rx[k-2]      = a_txd;
        rx_done[k-2] = a_done;
      end
      if (k < 4 && !a_ready) not_ready++;
      a_valid = (k < 4);
      a_data  = burst[k < 4 ? k : 0];
    end
    for (int f = 0; f < 4; f++) begin
      check("burst_frame", 64'(rx[10*f +: 10]), 64'(frame10(burst[f])));
      exp_done[10*f+9] = 1'b1;
    end
    check("burst_done", 64'(rx_done), 64'(exp_done));
    check("burst_ready", 64'(not_ready), 64'(0));
    check("burst_busy_end", 64'(a_busy), 64'(0));

    // Full FIFO: valid held high over 8 bytes
    idx = 0; rdy_prev = 1'b0; first_done = -1; rdy_early = 0; n_done = 0; bits = '0;
    a_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (a_valid && rdy_prev) idx++;
      bits[c] = a_txd;
      if (a_done) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (c >= 6 && first_done < 0 && a_ready) rdy_early++;
      if (c == 6) begin
        check("full_accepted", 64'(idx),     64'(5));
        check("full_count",    64'(a_count), 64'(4));
        check("full_ready",    64'(a_ready), 64'(0));
      end
      if (c == 12) check("full_ready_back", 64'(a_ready), 64'(1));
      rdy_prev = a_ready;
      a_valid  = (idx < 8);
      a_data   = fbytes[idx < 8 ? idx : 8];
    end
    check("full_first_done", 64'(first_done), 64'(11));
    check("full_ready_early", 64'(rdy_early), 64'(0));
    check("full_all_accepted", 64'(idx), 64'(8));
    check("full_ndone", 64'(n_done), 64'(8));
    for (int f = 0; f < 8; f++) begin
      check("full_frame", 64'(bits[2+10*f +: 10]), 64'(frame10(fbytes[f])));
    end
    check("full_busy_end", 64'(a_busy), 64'(0));

    // Reset during data bit 4 with 3 bytes queued
    a_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      a_valid = (k < 4);
      a_data  = mbytes[k < 4 ? k : 0];
    end
    check("mid_pre_txd",   64'(a_txd),   64'(0));
    check("mid_pre_count", 64'(a_count), 64'(3));
    a_rst = 1'b1;
    #1;
    check("mid_txd",   64'(a_txd),   64'(1));
    check("mid_count", 64'(a_count), 64'(0));
    check("mid_ready", 64'(a_ready), 64'(0));
    @(negedge clk);
    a_rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!a_txd || a_busy || a_done) bad++;
    end
    check("mid_quiet", 64'(bad), 64'(0));
    check("mid_count_end", 64'(a_count), 64'(0));

    // BAUD_DIV=3, STOP_BITS=2, byte 0x00: 27 low then 6 high
    bvec = '0; bdone = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      b_valid = (k == 0);
      b_data  = 8'h00;
      bvec[k]  = b_txd;
      bdone[k] = b_done;
      if (k == 34) check("b_busy_stop", 64'(b_busy), 64'(1));
    end
    bexp = '1;
    for (int k = 2; k < 29; k++) bexp[k] = 1'b0;
    check("b_txd", 64'(bvec), 64'(bexp));
    check("b_done", 64'(bdone), 64'(40'd1 << 34));
    check("b_busy_end", 64'(b_busy), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
